debounce_sync: RTL



---
 rtl/debounce_sync_pkg.sv | 13 +
 rtl/sync_2ff.sv | 24 ++
 rtl/debounce_sync.sv | 100 ++++++++++
 3 files changed

// File: rtl/debounce_sync_pkg.sv
// Shared constants for the debounce_sync block: FSM state encoding and the
// default timing for the 50 MHz board (10 ms stability window).
package debounce_sync_pkg;

  localparam int DEF_CNT_WIDTH     = 20;
  localparam int DEF_STABLE_CYCLES = 500000;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both flops load
// RESET_VALUE on reset so the output is defined before the first sample.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= RESET_VALUE;
      q         <= RESET_VALUE;
    end else begin
      sync1_reg <= d;
      q         <= sync1_reg;
    end
  end

endmodule

// File: rtl/debounce_sync.sv
// Synchronises and debounces a mechanical input. Optional registered edge
// pulses on RISE/FALL are built only when DEBOUNCE_EDGE_PULSE_EN is defined.
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int   CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D_RAW,
  output logic Q,
  output logic BUSY,
  output logic RISE,
  output logic FALL
);

  if ((STABLE_CYCLES < 2) ||
      (longint'(STABLE_CYCLES) > ((longint'(1) << CNT_WIDTH) - 1))) begin : g_bad_param
    $error("debounce_sync: STABLE_CYCLES out of range for CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 sync2;
  state_t               state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 q_reg;

  sync_2ff #(
    .RESET_VALUE(RESET_VALUE)
  ) u_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .d    (D_RAW),
    .q    (sync2)
  );

  // cnt counts consecutive samples that disagree with Q; exact compare, no wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_STABLE;
      cnt_reg   <= '0;
      q_reg     <= RESET_VALUE;
    end else begin
      unique case (state_reg)
        ST_STABLE: begin
          if (sync2 != q_reg) begin
            state_reg <= ST_CHECK;
            cnt_reg   <= CNT_WIDTH'(1);
          end else begin
            cnt_reg   <= '0;
          end
        end
        ST_CHECK: begin
          if (sync2 == q_reg) begin
            state_reg <= ST_STABLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == TERMINAL) begin
            q_reg     <= sync2;
            state_reg <= ST_STABLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign Q    = q_reg;
  assign BUSY = (state_reg == ST_CHECK);

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic commit;
  logic rise_reg;
  logic fall_reg;

  // Same condition that loads q_reg, so the pulse lands with the new Q.
  assign commit = (state_reg == ST_CHECK) && (sync2 != q_reg) && (cnt_reg == TERMINAL);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= commit & sync2;
      fall_reg <= commit & ~sync2;
    end
  end

  assign RISE = rise_reg;
  assign FALL = fall_reg;
`else
  assign RISE = 1'b0;
  assign FALL = 1'b0;
`endif

endmodule
